// File: rtl/spirose_pkg.sv
// Shared definitions for the slice read path.
//   IMAGE_WIDTH/IMAGE_HEIGHT/IMAGE_SIZE : geometry of one slice
//   pixel_t                             : 16-bit 5-6-5 pixel
//   slice_reader_state_t                : slice_reader FSM states
package spirose_pkg;
  localparam int IMAGE_WIDTH  = 40;
  localparam int IMAGE_HEIGHT = 48;
  localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pixel_t;

  typedef enum logic [1:0] {IDLE, WAIT_SLICE, READ, DRAIN} slice_reader_state_t;
endpackage

// File: rtl/slice_reader_if.sv
// RAM read port plus pixel stream towards the LED driver controller.
//   ram_addr/ram_read_enable : read request (reader -> RAM)
//   ram_data                 : read data, fixed latency (RAM -> reader)
//   pixel_data/pixel_valid   : pixel stream (reader -> driver)
//   pixel_ready              : backpressure (driver -> reader)
interface slice_reader_if #(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int RAM_DATA_WIDTH = 16
) ();
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      ram_read_enable;
  logic [RAM_DATA_WIDTH-1:0] ram_data;
  logic [15:0]               pixel_data;
  logic                      pixel_valid;
  logic                      pixel_ready;

  modport master (
    output ram_addr, ram_read_enable, pixel_data, pixel_valid,
    input  ram_data, pixel_ready
  );

  modport slave (
    input  ram_addr, ram_read_enable, pixel_data, pixel_valid,
    output ram_data, pixel_ready
  );
endinterface

// File: rtl/slice_reader_pixel_fifo.sv
// pixel_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write side (must not push when full unless popping)
//   pop, dout : read side, dout is the head whenever !empty
//   empty, full, count : occupancy
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Upstream credit accounting makes both of these impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop)) else $error("pixel_fifo overflow");
      assert (!(pop && empty)) else $error("pixel_fifo underflow");
    end
  end
endmodule

// File: rtl/slice_reader.sv
// slice_reader: once the write stage reports stream_ready, emits one slice
// (IMAGE_WIDTH x IMAGE_HEIGHT pixels, address order) per next_slice pulse,
// walking a circular store of IMAGE_IN_RAM slices. RAM read latency is
// absorbed by a credit-controlled skid FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   stream_ready  : RAM holds valid slices (level)
//   next_slice    : start emitting the next slice (pulse)
//   bus (master)  : RAM read port + pixel stream with ready/valid
//   slice_index   : index of slice being / last emitted
//   slice_done    : pulse on acceptance of the last pixel of a slice
//   overrun       : sticky, next_slice arrived while a slice was in progress
// Build option: SLICE_READER_TEST_PATTERN_EN replaces RAM data with a
// generated {slice_index, row, col} pattern and never asserts ram_read_enable.
module slice_reader
  import spirose_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int RAM_DATA_WIDTH = 16,
  parameter int IMAGE_IN_RAM   = 18,
  parameter int IMAGE_WIDTH    = spirose_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT   = spirose_pkg::IMAGE_HEIGHT,
  parameter int READ_LATENCY   = 2,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stream_ready,
  input  logic           next_slice,
  slice_reader_if.master bus,
  output logic [4:0]     slice_index,
  output logic           slice_done,
  output logic           overrun
);
  localparam int SLICE_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int RAM_END      = SLICE_PIXELS * IMAGE_IN_RAM - 1;
  localparam int RCW          = $clog2(SLICE_PIXELS);
  localparam int CW           = $clog2(FIFO_DEPTH + 1);
  localparam int OW           = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  slice_reader_state_t state_q, state_d;

  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RCW-1:0]            req_cnt_q;
  logic [READ_LATENCY:1]     vld_pipe;   // [i] = a read issued i cycles ago
  logic                      first_q;    // next slice is the first since reset

  logic          req, credit, last_req, enter_read, final_pop;
  logic          push, pop, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic [15:0]   fifo_din, fifo_dout;
  logic [OW-1:0] outstanding;

  // Everything requested but not yet handed to the consumer must fit in
  // the FIFO, so a returning word always has a slot.
  assign outstanding = OW'(fifo_count) + OW'($countones(vld_pipe));
  assign credit      = outstanding < OW'(FIFO_DEPTH);
  assign last_req    = (req_cnt_q == RCW'(SLICE_PIXELS - 1));
  assign push        = vld_pipe[READ_LATENCY];
  assign pop         = !fifo_empty && bus.pixel_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (stream_ready) state_d = WAIT_SLICE;
      WAIT_SLICE: if (!stream_ready) state_d = IDLE;
                  else if (next_slice) state_d = READ;
      READ:       if (req && last_req) state_d = DRAIN;
      DRAIN:      if (final_pop) state_d = stream_ready ? WAIT_SLICE : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req        = 1'b0;
    enter_read = 1'b0;
    final_pop  = 1'b0;
    case (state_q)
      WAIT_SLICE: enter_read = stream_ready && next_slice;
      READ:       req        = credit;
      // All reads have landed and one word remains: it is the last pixel.
      DRAIN:      final_pop  = pop && (fifo_count == CW'(1)) && (vld_pipe == '0);
      default:    ;
    endcase
  end

  assign slice_done = final_pop;

  // ---------------- address walk, slice index, overrun ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      req_cnt_q   <= '0;
      vld_pipe    <= '0;
      first_q     <= 1'b1;
      slice_index <= '0;
      overrun     <= 1'b0;
    end else begin
      if (req) begin
        addr_q    <= (addr_q == RAM_ADDR_WIDTH'(RAM_END)) ? '0 : addr_q + 1'b1;
        req_cnt_q <= last_req ? '0 : req_cnt_q + 1'b1;
      end
      vld_pipe[1] <= req;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      // The address counter runs continuously, so the index just steps
      // alongside it and stays equal to slice base / slice size.
      if (enter_read) begin
        if (first_q) first_q <= 1'b0;
        else slice_index <= (slice_index == 5'(IMAGE_IN_RAM - 1)) ? '0 : slice_index + 1'b1;
      end
      if (next_slice && (state_q == READ || state_q == DRAIN)) overrun <= 1'b1;
    end
  end

  assign bus.ram_addr = addr_q;

`ifdef SLICE_READER_TEST_PATTERN_EN
  // Generator tracks the push side; slice_index cannot change while pushes
  // of the current slice are still pending.
  logic [5:0] gen_col, gen_row;
  pixel_t     gen_pix;

  always_ff @(posedge clk) begin
    if (rst || enter_read) begin
      gen_col <= '0;
      gen_row <= '0;
    end else if (push) begin
      if (gen_col == 6'(IMAGE_WIDTH - 1)) begin
        gen_col <= '0;
        gen_row <= gen_row + 1'b1;
      end else begin
        gen_col <= gen_col + 1'b1;
      end
    end
  end

  always_comb begin
    gen_pix.r = slice_index;
    gen_pix.g = gen_row;
    gen_pix.b = gen_col[4:0];
  end

  assign fifo_din            = gen_pix;
  assign bus.ram_read_enable = 1'b0;
`else
  assign fifo_din            = bus.ram_data[15:0];
  assign bus.ram_read_enable = req;
`endif

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bus.pixel_valid = !fifo_empty;
  assign bus.pixel_data  = fifo_empty ? 16'h0 : fifo_dout;
endmodule

// File: tb/tb_slice_reader.sv
module tb_slice_reader;
  localparam int PIX    = 1920;
  localparam int NSLICE = 18;
  localparam int DEPTH  = 8;

  logic       clk, rst, stream_ready, next_slice;
  logic [4:0] slice_index;
  logic       slice_done, overrun;

  slice_reader_if bus ();

  slice_reader dut (
    .clk          (clk),
    .rst          (rst),
    .stream_ready (stream_ready),
    .next_slice   (next_slice),
    .bus          (bus),
    .slice_index  (slice_index),
    .slice_done   (slice_done),
    .overrun      (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: word = address, two-cycle read latency.
  logic [15:0] ram_p1, ram_p2;
  always @(posedge clk) begin
    ram_p1 <= bus.ram_addr[15:0];
    ram_p2 <= ram_p1;
  end
  assign bus.ram_data = ram_p2;

  typedef struct {
    logic [15:0] d;
    bit          last;
    bit          first;
    int          idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   k_slice = 0;       // slices started since reset
  int   outstanding = 0;   // requests issued minus pixels accepted
  int   reqs = 0;          // requests since reset
  bit   rnd_mode = 0, saw_full = 0;
  int   lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Consumer: always ready, or ready 30% of cycles in random mode.
  initial begin
    bus.pixel_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.pixel_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted pixel.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      reqs = 0;
    end else begin
      if (bus.ram_read_enable) begin
        chk("read_credit", 32'(outstanding < DEPTH), 1);
        reqs++;
      end
      if (bus.pixel_valid && bus.pixel_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_pixel: got pixel %0d, expected no pixel", bus.pixel_data);
        end else begin
          mon_e = sb.pop_front();
          chk("pixel_data", bus.pixel_data, mon_e.d);
          chk("slice_done", slice_done, mon_e.last);
          if (mon_e.first) chk("slice_index", slice_index, mon_e.idx);
        end
      end else if (slice_done) begin
        n_chk++; n_fail++;
        $display("FAIL stray_slice_done: got 1 with no pixel accepted, expected 0");
      end
      outstanding += int'(bus.ram_read_enable) - int'(bus.pixel_valid && bus.pixel_ready);
      if (outstanding == DEPTH) saw_full = 1;
    end
  end

  task automatic pulse_next();
    @(posedge clk); #1 next_slice = 1'b1;
    @(posedge clk); #1 next_slice = 1'b0;
  endtask

  // Expected slice = slice k mod 18 of the circular store; words = addresses.
  task automatic start_slice();
    int idx = k_slice % NSLICE;
    for (int i = 0; i < PIX; i++) begin
      exp_t e;
      e.d = 16'(idx * PIX + i);
      e.last = (i == PIX - 1);
      e.first = (i == 0);
      e.idx = idx;
      sb.push_back(e);
    end
    k_slice++;
    pulse_next();
    chk("slice_base_addr", bus.ram_addr, idx * PIX);
    chk("first_read_issued", bus.ram_read_enable, 1);
  endtask

  task automatic wait_left(input int left, input int budget, input string nm);
    int c = 0;
    while (sb.size() > left && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (sb.size() > left) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d pixels pending, expected %0d", nm, sb.size(), left);
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ram_addr"}, bus.ram_addr, 0);
    chk({nm, "_ram_read_enable"}, bus.ram_read_enable, 0);
    chk({nm, "_pixel_valid"}, bus.pixel_valid, 0);
    chk({nm, "_pixel_data"}, bus.pixel_data, 0);
    chk({nm, "_slice_index"}, slice_index, 0);
    chk({nm, "_slice_done"}, slice_done, 0);
    chk({nm, "_overrun"}, overrun, 0);
  endtask

  initial begin
    rst = 1'b1; stream_ready = 1'b0; next_slice = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst = 1'b0; stream_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Slice 0: latency from READ entry to first pixel_valid.
    start_slice();
    lat = 0;
    while (!bus.pixel_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_pixel_latency", lat, 3);
    wait_left(0, PIX + 8, "slice0");
    chk("slice0_reqs", reqs, PIX);

    // Slices 1..18 at full rate: index walks 1..17 then wraps to 0 at addr 0.
    for (int s = 1; s <= NSLICE; s++) begin
      start_slice();
      wait_left(0, PIX + 8, "full_rate");
    end
    chk("wrap_reqs", reqs, (NSLICE + 1) * PIX);

    // Random 30% backpressure: credit limit must be reached and respected.
    rnd_mode = 1; saw_full = 0;
    start_slice();
    wait_left(0, 25000, "random_ready");
    rnd_mode = 0;
    chk("credit_limit_reached", saw_full, 1);
    chk("random_reqs", reqs, (NSLICE + 2) * PIX);
    repeat (4) @(posedge clk); #1;

    // Reset mid-READ with reads in flight.
    start_slice();
    wait_left(PIX - 100, 3000, "pre_reset");
    rst = 1'b1;
    sb.delete();
    k_slice = 0;
    @(posedge clk); #1;
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    lat = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.pixel_valid) lat++;
    end
    chk("stale_pixels_after_reset", lat, 0);
    chk("reqs_after_reset", reqs, 0);
    start_slice();
    wait_left(0, PIX + 8, "post_reset");

    // next_slice at pixel 500: overrun, slice completes, nothing extra.
    chk("overrun_before", overrun, 0);
    start_slice();
    wait_left(PIX - 500, 3000, "pre_overrun");
    pulse_next();
    chk("overrun_set", overrun, 1);
    wait_left(0, PIX + 8, "overrun_slice");
    repeat (20) @(posedge clk); #1;
    chk("no_extra_slice_valid", bus.pixel_valid, 0);
    chk("no_extra_slice_reqs", reqs, 2 * PIX);
    chk("overrun_sticky", overrun, 1);

    // stream_ready dropped mid-slice: slice completes, then idle.
    start_slice();
    wait_left(PIX - 300, 3000, "pre_drop");
    stream_ready = 1'b0;
    wait_left(0, PIX + 8, "drop_slice");
    repeat (5) @(posedge clk); #1;
    pulse_next();
    repeat (30) @(posedge clk); #1;
    chk("idle_ignores_next_reqs", reqs, 3 * PIX);
    chk("idle_ignores_next_valid", bus.pixel_valid, 0);
    stream_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("ready_again_no_start", reqs, 3 * PIX);
    chk("sb_empty_at_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
